// File: rtl/ej32_mem_arb_pkg.sv
// Shared types and constants for the eJ32 SPRAM arbiter and byte sequencer.
package ej32_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } arb_st_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LS   = 2'd1,
    SRC_IF   = 2'd2,
    SRC_DBG  = 2'd3
  } arb_src_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Index of the last byte of a transfer (nbytes-1); the reserved size code
  // behaves like a word.
  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    case (sz)
      SZ_B:    last_idx = 2'd0;
      SZ_H:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/ej32_mem_arb_if.sv
// Requester handshakes and the 8-bit SPRAM port of the eJ32 memory arbiter.
// Optional debug port signals exist only when EJ32_ARB_DBG_EN is defined.
//
// Handshake: a requester raises *_req with its address/size/data and holds
// them until *_gnt pulses (one cycle, same cycle as the winning req). After
// gnt the inputs are don't-care and dropping req does not abort. *_done
// pulses for one cycle when the transfer ends; rdata is valid with it.
// req still high in the cycle after done is a new request.
//
// The slave modport is the arbiter's view; master is the core + memory side.
interface ej32_mem_arb_if #(
  parameter int ASZ = 17,
  parameter int DSZ = 32
) ();
  logic           if_req;
  logic [ASZ-1:0] if_a;
  logic           ls_req;
  logic           ls_we;
  logic [1:0]     ls_sz;
  logic [ASZ-1:0] ls_a;
  logic [DSZ-1:0] ls_wd;
`ifdef EJ32_ARB_DBG_EN
  logic           dbg_req;
  logic           dbg_we;
  logic [ASZ-1:0] dbg_a;
  logic [7:0]     dbg_wd;
  logic           dbg_gnt;
  logic           dbg_done;
`endif
  logic           if_gnt;
  logic           ls_gnt;
  logic           if_done;
  logic           ls_done;
  logic [DSZ-1:0] rdata;
  logic           busy;
  logic [ASZ-1:0] mem_a;
  logic           mem_we;
  logic [7:0]     mem_vi;
  logic [7:0]     mem_vo;

  modport slave (
`ifdef EJ32_ARB_DBG_EN
    input  dbg_req, dbg_we, dbg_a, dbg_wd,
    output dbg_gnt, dbg_done,
`endif
    input  if_req, if_a, ls_req, ls_we, ls_sz, ls_a, ls_wd, mem_vo,
    output if_gnt, ls_gnt, if_done, ls_done, rdata, busy,
    output mem_a, mem_we, mem_vi
  );

  modport master (
`ifdef EJ32_ARB_DBG_EN
    output dbg_req, dbg_we, dbg_a, dbg_wd,
    input  dbg_gnt, dbg_done,
`endif
    output if_req, if_a, ls_req, ls_we, ls_sz, ls_a, ls_wd, mem_vo,
    input  if_gnt, ls_gnt, if_done, ls_done, rdata, busy,
    input  mem_a, mem_we, mem_vi
  );
endinterface

// File: rtl/ej32_mem_arb_seq.sv
// ej32_mb8_seq: byte counter, address incrementer and big-endian
// shift-in/shift-out datapath for one 1/2/4-byte SPRAM transfer.
module ej32_mb8_seq
  import ej32_mem_arb_pkg::*;
#(
  parameter int ASZ = 17,
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           xfer,
  input  logic [ASZ-1:0] a,
  input  logic           we,
  input  logic [1:0]     sz,
  input  logic [DSZ-1:0] wd,
  input  logic [7:0]     mem_vo,
  output logic           last,
  output logic [ASZ-1:0] mem_a,
  output logic           mem_we,
  output logic [7:0]     mem_vi,
  output logic [DSZ-1:0] rdata
);
  logic [1:0]     cnt;
  logic [ASZ-1:0] addr;
  logic           we_q;
  logic [DSZ-1:0] wsh;
  logic [DSZ-1:0] rdata_q;

  // Latch a transfer on load, then step one byte per XFER cycle. The address
  // register doubles as mem_a so it holds its last value between transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 2'd0;
      addr    <= '0;
      we_q    <= 1'b0;
      wsh     <= '0;
      rdata_q <= '0;
    end else if (load) begin
      cnt     <= last_idx(sz);
      addr    <= a;
      we_q    <= we;
      // Left-align the n-byte value so its MSB byte goes out first.
      wsh     <= wd << (DSZ - 8 * (int'(last_idx(sz)) + 1));
      rdata_q <= '0;
    end else if (xfer) begin
      if (!we_q) rdata_q <= {rdata_q[DSZ-9:0], mem_vo};
      wsh <= wsh << 8;
      if (cnt != 2'd0) begin
        cnt  <= cnt - 2'd1;
        addr <= addr + ASZ'(1);
      end
    end
  end

  // Bus drive is gated by xfer, which comes straight from the FSM register,
  // so reset removes mem_we without waiting for a clock.
  always_comb begin
    last   = (cnt == 2'd0);
    mem_a  = addr;
    mem_we = xfer & we_q;
    mem_vi = (xfer & we_q) ? wsh[DSZ-1 -: 8] : 8'h00;
    rdata  = rdata_q;
  end

endmodule

// File: rtl/ej32_mem_arb.sv
// ej32_mem_arb: grants the single 8-bit SPRAM port to LS > IF (> DBG) and
// runs the transfer through ej32_mb8_seq. Define EJ32_ARB_DBG_EN to add the
// lowest-priority byte-wide debug port.
module ej32_mem_arb
  import ej32_mem_arb_pkg::*;
#(
  parameter int ASZ = 17,
  parameter int DSZ = 32
) (
  input  logic          clk,
  input  logic          rst,
  ej32_mem_arb_if.slave bus,
  output arb_st_t       fsm_state
);
  arb_st_t        state_q, state_d;
  arb_src_t       src_q, src_d, win;
  logic [ASZ-1:0] sel_a;
  logic           sel_we;
  logic [1:0]     sel_sz;
  logic [DSZ-1:0] sel_wd;
  logic           load, last, xfer;
  logic [ASZ-1:0] seq_mem_a;
  logic           seq_mem_we;
  logic [7:0]     seq_mem_vi;
  logic [DSZ-1:0] seq_rdata;

  // Fixed-priority pick among live requesters and mux of the winner's inputs.
  always_comb begin
    win    = SRC_NONE;
    sel_a  = '0;
    sel_we = 1'b0;
    sel_sz = SZ_B;
    sel_wd = '0;
    if (bus.ls_req) begin
      win    = SRC_LS;
      sel_a  = bus.ls_a;
      sel_we = bus.ls_we;
      sel_sz = bus.ls_sz;
      sel_wd = bus.ls_wd;
    end else if (bus.if_req) begin
      win   = SRC_IF;
      sel_a = bus.if_a;
    end
`ifdef EJ32_ARB_DBG_EN
    else if (bus.dbg_req) begin
      win    = SRC_DBG;
      sel_a  = bus.dbg_a;
      sel_we = bus.dbg_we;
      sel_wd = {{(DSZ-8){1'b0}}, bus.dbg_wd};
    end
`endif
  end

  // State and owner registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= SRC_NONE;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
    end
  end

  // Next state; requests are only looked at in IDLE, and never during reset.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win != SRC_NONE && !rst) begin
          load    = 1'b1;
          src_d   = win;
          state_d = XFER;
        end
      end
      XFER: if (last) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        src_d   = SRC_NONE;
      end
      default: begin
        state_d = IDLE;
        src_d   = SRC_NONE;
      end
    endcase
  end

  assign xfer = (state_q == XFER);

  ej32_mb8_seq #(.ASZ(ASZ), .DSZ(DSZ)) u_seq (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .xfer   (xfer),
    .a      (sel_a),
    .we     (sel_we),
    .sz     (sel_sz),
    .wd     (sel_wd),
    .mem_vo (bus.mem_vo),
    .last   (last),
    .mem_a  (seq_mem_a),
    .mem_we (seq_mem_we),
    .mem_vi (seq_mem_vi),
    .rdata  (seq_rdata)
  );

  // Grant pulses follow the IDLE pick; done pulses follow the owner in DONE.
  always_comb begin
    bus.ls_gnt  = load && (win == SRC_LS);
    bus.if_gnt  = load && (win == SRC_IF);
    bus.ls_done = (state_q == DONE) && (src_q == SRC_LS);
    bus.if_done = (state_q == DONE) && (src_q == SRC_IF);
`ifdef EJ32_ARB_DBG_EN
    bus.dbg_gnt  = load && (win == SRC_DBG);
    bus.dbg_done = (state_q == DONE) && (src_q == SRC_DBG);
`endif
    bus.busy   = (state_q != IDLE);
    bus.rdata  = seq_rdata;
    bus.mem_a  = seq_mem_a;
    bus.mem_we = seq_mem_we;
    bus.mem_vi = seq_mem_vi;
    fsm_state  = state_q;
  end

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Self-checking bench for ej32_mem_arb with a negedge-registered SPRAM model.
// Covers the EJ32_ARB_DBG_EN port when that macro is defined.
module tb_ej32_mem_arb;
  import ej32_mem_arb_pkg::*;

  localparam int ASZ = 17;
  localparam int DSZ = 32;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  arb_st_t fsm_state;
  int      checks = 0;
  int      failures = 0;
  logic [DSZ-1:0] exp_q[$];
  logic [7:0] mem [0:(1<<ASZ)-1];
  logic    any_done;

  ej32_mem_arb_if #(.ASZ(ASZ), .DSZ(DSZ)) bus ();

  ej32_mem_arb #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    bus.mem_vo <= mem[bus.mem_a];
    if (bus.mem_we) mem[bus.mem_a] = bus.mem_vi;
  end

`ifdef EJ32_ARB_DBG_EN
  assign any_done = bus.ls_done | bus.if_done | bus.dbg_done;
`else
  assign any_done = bus.ls_done | bus.if_done;
`endif

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && any_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done rdata=%h expected no done", bus.rdata);
      end else begin
        logic [DSZ-1:0] e;
        e = exp_q.pop_front();
        if (bus.rdata !== e) begin
          failures++;
          $display("FAIL sb_rdata got=%h exp=%h", bus.rdata, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_a = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_sz = SZ_B;
    bus.ls_a = '0; bus.ls_wd = '0;
`ifdef EJ32_ARB_DBG_EN
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_a = '0; bus.dbg_wd = '0;
`endif
  endtask

  task automatic test_reset();
    // Values while reset is held, with a live LS request that must not grant.
    bus.ls_req = 1'b1; bus.ls_a = 17'h00123;
    #2;
    checks++;
    if (fsm_state !== IDLE) begin
      failures++; $display("FAIL rst_state got=%0d exp=%0d", fsm_state, IDLE);
    end
    checks++;
    if ({bus.busy, bus.mem_we, bus.mem_vi, bus.ls_gnt, bus.if_gnt,
         bus.ls_done, bus.if_done} !== 13'd0) begin
      failures++;
      $display("FAIL rst_outputs busy=%b we=%b vi=%h lsg=%b ifg=%b lsd=%b ifd=%b exp all 0",
               bus.busy, bus.mem_we, bus.mem_vi, bus.ls_gnt, bus.if_gnt, bus.ls_done, bus.if_done);
    end
    checks++;
    if (bus.mem_a !== 17'd0 || bus.rdata !== 32'd0) begin
      failures++; $display("FAIL rst_bus mem_a=%h rdata=%h exp 0", bus.mem_a, bus.rdata);
    end
    bus.ls_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Abort an LS word write in its second byte cycle.
    mem[17'h00302] = 8'h5A;
    @(posedge clk); #1;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_sz = SZ_W;
    bus.ls_a = 17'h00300; bus.ls_wd = 32'h11223344;
    @(negedge clk);
    checks++;
    if (bus.ls_gnt !== 1'b1) begin
      failures++; $display("FAIL rst_abort_gnt got=%b exp=1", bus.ls_gnt);
    end
    @(posedge clk); #1 bus.ls_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_vi !== 8'h11) begin
      failures++; $display("FAIL rst_abort_byte0 we=%b vi=%h exp 1/11", bus.mem_we, bus.mem_vi);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || fsm_state !== IDLE || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_abort_async we=%b state=%0d busy=%b exp 0/IDLE/0", bus.mem_we, fsm_state, bus.busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.ls_done !== 1'b0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL rst_abort_nodone cyc=%0d done=%b busy=%b exp 0/0", c, bus.ls_done, bus.busy);
      end
    end
    checks++;
    if (mem[17'h00302] !== 8'h5A || mem[17'h00301] !== 8'h22) begin
      failures++;
      $display("FAIL rst_abort_mem m301=%h m302=%h exp 22/5A", mem[17'h00301], mem[17'h00302]);
    end
  endtask

  task automatic test_if_read();
    mem[17'h00100] = 8'hA7;
    exp_q.push_back(32'h000000A7);
    @(posedge clk); #1 bus.if_req = 1'b1; bus.if_a = 17'h00100;
    @(negedge clk);
    checks++;
    if (bus.if_gnt !== 1'b1 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL if_gnt got=%b busy=%b exp 1/0", bus.if_gnt, bus.busy);
    end
    @(posedge clk); #1 bus.if_req = 1'b0; bus.if_a = 17'h1ABCD;
    @(negedge clk);
    checks++;
    if (bus.mem_a !== 17'h00100 || bus.mem_we !== 1'b0 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL if_xfer mem_a=%h we=%b busy=%b exp 00100/0/1", bus.mem_a, bus.mem_we, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.if_done !== 1'b1) begin
      failures++; $display("FAIL if_done got=%b exp=1", bus.if_done);
    end
  endtask

  task automatic test_ls_read();
    logic [1:0]     sz_tab  [3];
    logic [DSZ-1:0] exp_tab [3];
    int             n_tab   [3];
    sz_tab[0] = SZ_W; exp_tab[0] = 32'h12345678; n_tab[0] = 4;
    sz_tab[1] = SZ_H; exp_tab[1] = 32'h00001234; n_tab[1] = 2;
    sz_tab[2] = SZ_B; exp_tab[2] = 32'h00000012; n_tab[2] = 1;
    mem[17'h00200] = 8'h12; mem[17'h00201] = 8'h34;
    mem[17'h00202] = 8'h56; mem[17'h00203] = 8'h78;
    for (int t = 0; t < 3; t++) begin
      exp_q.push_back(exp_tab[t]);
      @(posedge clk); #1;
      bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_sz = sz_tab[t]; bus.ls_a = 17'h00200;
      @(negedge clk);
      checks++;
      if (bus.ls_gnt !== 1'b1) begin
        failures++; $display("FAIL ls_rd_gnt t=%0d got=%b exp=1", t, bus.ls_gnt);
      end
      @(posedge clk); #1 bus.ls_req = 1'b0; bus.ls_a = 17'h0;
      for (int i = 0; i < n_tab[t]; i++) begin
        @(negedge clk);
        checks++;
        if (bus.mem_a !== 17'(17'h00200 + i) || bus.mem_we !== 1'b0) begin
          failures++; $display("FAIL ls_rd_addr t=%0d i=%0d mem_a=%h we=%b exp %h/0",
                               t, i, bus.mem_a, bus.mem_we, 17'(17'h00200 + i));
        end
      end
      @(negedge clk);
      checks++;
      if (bus.ls_done !== 1'b1) begin
        failures++; $display("FAIL ls_rd_done t=%0d got=%b exp=1", t, bus.ls_done);
      end
    end
  endtask

  task automatic test_ls_write_wrap();
    logic [DSZ-1:0] wd;
    logic [ASZ-1:0] ea;
    logic [7:0]     eb;
    wd = 32'hDEADBEEF;
    exp_q.push_back(32'h0);
    @(posedge clk); #1;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_sz = SZ_W;
    bus.ls_a = 17'h1FFFE; bus.ls_wd = wd;
    @(negedge clk);
    checks++;
    if (bus.ls_gnt !== 1'b1) begin
      failures++; $display("FAIL wr_gnt got=%b exp=1", bus.ls_gnt);
    end
    @(posedge clk); #1 bus.ls_req = 1'b0; bus.ls_wd = 32'h0; bus.ls_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ea = 17'(17'h1FFFE + i);
      eb = 8'(wd >> (8 * (3 - i)));
      @(negedge clk);
      checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_a !== ea || bus.mem_vi !== eb) begin
        failures++; $display("FAIL wr_byte i=%0d we=%b a=%h vi=%h exp 1/%h/%h",
                             i, bus.mem_we, bus.mem_a, bus.mem_vi, ea, eb);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.ls_done !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_vi !== 8'h00 ||
        bus.mem_a !== 17'h00001) begin
      failures++; $display("FAIL wr_done done=%b we=%b vi=%h a=%h exp 1/0/00/00001",
                           bus.ls_done, bus.mem_we, bus.mem_vi, bus.mem_a);
    end
    checks++;
    if ({mem[17'h1FFFE], mem[17'h1FFFF], mem[17'h00000], mem[17'h00001]} !== wd) begin
      failures++; $display("FAIL wr_mem got=%h%h%h%h exp=%h",
                           mem[17'h1FFFE], mem[17'h1FFFF], mem[17'h00000], mem[17'h00001], wd);
    end
  endtask

  task automatic test_contention();
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h000000A7);
    @(posedge clk); #1;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_sz = SZ_W; bus.ls_a = 17'h00200;
    bus.if_req = 1'b1; bus.if_a = 17'h00100;
    @(negedge clk);
    checks++;
    if (bus.ls_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
      failures++; $display("FAIL cont_first lsg=%b ifg=%b exp 1/0", bus.ls_gnt, bus.if_gnt);
    end
    @(posedge clk); #1 bus.ls_req = 1'b0; bus.ls_a = 17'h0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.if_gnt !== 1'b0 || bus.ls_done !== (c == 5)) begin
        failures++; $display("FAIL cont_wait c=%0d ifg=%b lsd=%b exp 0/%b", c, bus.if_gnt, bus.ls_done, c == 5);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      failures++; $display("FAIL cont_if_gnt got=%b exp=1", bus.if_gnt);
    end
    @(posedge clk); #1 bus.if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.if_done !== 1'b1) begin
      failures++; $display("FAIL cont_if_done got=%b exp=1", bus.if_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals[0] = 8'hA7; vals[1] = 8'h3C; vals[2] = 8'hC3;
    mem[17'h00100] = vals[0]; mem[17'h00101] = vals[1]; mem[17'h00102] = vals[2];
    exp_q.push_back({24'h0, vals[0]});
    @(posedge clk); #1 bus.if_req = 1'b1; bus.if_a = 17'h00100;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checks++;
      if (bus.if_gnt !== 1'b1) begin
        failures++; $display("FAIL b2b_gnt t=%0d got=%b exp=1", t, bus.if_gnt);
      end
      @(posedge clk); #1;
      if (t < 2) begin
        bus.if_a = 17'(17'h00101 + t);
        exp_q.push_back({24'h0, vals[t+1]});
      end else begin
        bus.if_req = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (bus.if_gnt !== 1'b0 || bus.busy !== 1'b1) begin
        failures++; $display("FAIL b2b_xfer t=%0d gnt=%b busy=%b exp 0/1", t, bus.if_gnt, bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.if_done !== 1'b1 || bus.if_gnt !== 1'b0) begin
        failures++; $display("FAIL b2b_done t=%0d done=%b gnt=%b exp 1/0", t, bus.if_done, bus.if_gnt);
      end
    end
  endtask

  task automatic test_random_ls();
    logic           we;
    logic [1:0]     sz;
    logic [ASZ-1:0] a;
    logic [DSZ-1:0] wd, e;
    int             n, dcyc;
    logic           got;
    for (int t = 0; t < 12; t++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 17'($urandom_range(0, 17'h1FFFF));
      if ($urandom_range(0, 3) == 0) a = 17'(17'h1FFFF - $urandom_range(0, 2));
      wd = $urandom;
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      e  = '0;
      if (!we) for (int i = 0; i < n; i++) e = (e << 8) | {24'h0, mem[17'(a + i)]};
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_sz = sz; bus.ls_a = a; bus.ls_wd = wd;
      @(negedge clk);
      checks++;
      if (bus.ls_gnt !== 1'b1) begin
        failures++; $display("FAIL rnd_gnt t=%0d got=%b exp=1", t, bus.ls_gnt);
      end
      @(posedge clk); #1;
      bus.ls_req = 1'b0; bus.ls_a = 17'($urandom); bus.ls_wd = $urandom;
      bus.ls_sz = 2'($urandom); bus.ls_we = 1'($urandom);
      got = 1'b0; dcyc = 0;
      for (int c = 1; c <= 8 && !got; c++) begin
        @(negedge clk);
        if (bus.ls_done) begin got = 1'b1; dcyc = c; end
      end
      checks++;
      if (!got || dcyc != n + 1) begin
        failures++; $display("FAIL rnd_latency t=%0d seen=%b cyc=%0d exp done at %0d", t, got, dcyc, n + 1);
      end
      if (we) begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (mem[17'(a + i)] !== 8'(wd >> (8 * (n - 1 - i)))) begin
            failures++; $display("FAIL rnd_wr_mem t=%0d a=%h got=%h exp=%h",
                                 t, 17'(a + i), mem[17'(a + i)], 8'(wd >> (8 * (n - 1 - i))));
          end
        end
      end
    end
  endtask

`ifdef EJ32_ARB_DBG_EN
  task automatic test_dbg();
    exp_q.push_back(32'h000000A7);
    exp_q.push_back(32'h000000A7);
    exp_q.push_back(32'h0);
    mem[17'h00100] = 8'hA7;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_a = 17'h00100;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_a = 17'h00400; bus.dbg_wd = 8'h66;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.dbg_gnt !== 1'b0 || bus.if_gnt !== (c == 0 || c == 3)) begin
        failures++; $display("FAIL dbg_wait c=%0d dbgg=%b ifg=%b exp 0/%b", c, bus.dbg_gnt, bus.if_gnt, c == 0 || c == 3);
      end
      if (c == 3) begin
        @(posedge clk); #1 bus.if_req = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (bus.dbg_gnt !== 1'b1) begin
      failures++; $display("FAIL dbg_gnt got=%b exp=1", bus.dbg_gnt);
    end
    @(posedge clk); #1 bus.dbg_req = 1'b0; bus.dbg_wd = 8'h00;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_a !== 17'h00400 || bus.mem_vi !== 8'h66) begin
      failures++; $display("FAIL dbg_byte we=%b a=%h vi=%h exp 1/00400/66", bus.mem_we, bus.mem_a, bus.mem_vi);
    end
    @(negedge clk);
    checks++;
    if (bus.dbg_done !== 1'b1) begin
      failures++; $display("FAIL dbg_done got=%b exp=1", bus.dbg_done);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'(i ^ (i >> 8));
    idle_inputs();
    test_reset();
    test_if_read();
    test_ls_read();
    test_ls_write_wrap();
    test_contention();
    test_back_to_back();
    test_random_ls();
`ifdef EJ32_ARB_DBG_EN
    test_dbg();
`endif
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
